iq_split: RTL

- Transmit-side counterpart of the receive-side I/Q recombiner; feeds the QPSK mapper/modulator.
- Takes a handshaked serial bit stream and pairs the bits: first bit is I, second bit is Q.
- Buffers the resulting dibits and emits one (I,Q) symbol every SYM_CYCLES clocks, with a one-cycle sync_flag_o strobe per symbol.

---
 rtl/qpsk_pkg.sv | 32 +++
 rtl/iq_split_if.sv | 29 ++
 rtl/iq_sym_fifo.sv | 74 +++++++
 rtl/iq_split.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/qpsk_pkg.sv
// -----------------------------------------------------------------------------
// qpsk_pkg
// Shared types and constants for the QPSK transmit path (iq_split and friends).
//   dibit_t     : 2-bit symbol, I in the MSB, Q in the LSB.
//   sch_state_e : symbol scheduler states {IDLE, RUN}.
//   asm_state_e : serial-to-dibit assembler states {WAIT_I, WAIT_Q}.
//   gray2phase / phase2gray : Gray <-> quadrant-phase lookups used by the
//   optional differential encoder (IQ_DIFF_ENC_EN).
// -----------------------------------------------------------------------------
package qpsk_pkg;

  typedef logic [1:0] dibit_t;

  typedef enum logic {IDLE, RUN} sch_state_e;

  typedef enum logic {WAIT_I, WAIT_Q} asm_state_e;

  // Packed 4-entry tables, entry k lives in bits [2k+1:2k].
  // Gray -> phase: 00->0, 01->1, 10->3, 11->2
  localparam logic [7:0] GRAY2PHASE_LUT = {2'd2, 2'd3, 2'd1, 2'd0};
  // Phase -> Gray: 0->00, 1->01, 2->11, 3->10
  localparam logic [7:0] PHASE2GRAY_LUT = {2'b10, 2'b11, 2'b01, 2'b00};

  function automatic logic [1:0] gray2phase(input dibit_t g);
    return GRAY2PHASE_LUT[{g, 1'b0} +: 2];
  endfunction

  function automatic dibit_t phase2gray(input logic [1:0] p);
    return PHASE2GRAY_LUT[{p, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/iq_split_if.sv
// -----------------------------------------------------------------------------
// iq_split_if
// Bundles the serial input handshake and the symbol-rate outputs of iq_split.
//   ser_i, ser_valid_i : serial bit + valid (source -> splitter)
//   ser_ready_o        : splitter accepts the bit this cycle
//   sync_I, sync_Q     : current symbol, held for a full symbol period
//   sync_flag_o        : one-cycle strobe on the first cycle of a new symbol
//   underflow_o        : one-cycle strobe when a symbol tick finds no data
// master = bit source / symbol consumer side, slave = iq_split.
// -----------------------------------------------------------------------------
interface iq_split_if;
  logic ser_i;
  logic ser_valid_i;
  logic ser_ready_o;
  logic sync_I;
  logic sync_Q;
  logic sync_flag_o;
  logic underflow_o;

  modport master (
    output ser_i, ser_valid_i,
    input  ser_ready_o, sync_I, sync_Q, sync_flag_o, underflow_o
  );

  modport slave (
    input  ser_i, ser_valid_i,
    output ser_ready_o, sync_I, sync_Q, sync_flag_o, underflow_o
  );
endinterface

// File: rtl/iq_sym_fifo.sv
// -----------------------------------------------------------------------------
// iq_sym_fifo
// Synchronous dibit FIFO with registered read data.
//   clk, rst_n      : clock, asynchronous active-low reset (empties the FIFO)
//   push, push_data : write a dibit (ignored when full)
//   pop             : read a dibit (ignored when empty); rd_data is valid the
//                     cycle after the pop
//   full, empty     : occupancy flags, derived from the registered count only
// Pointers are log2(DEPTH) bits and wrap naturally; count is one bit wider.
// -----------------------------------------------------------------------------
module iq_sym_fifo
  import qpsk_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  dibit_t push_data,
  input  logic   pop,
  output dibit_t rd_data,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  dibit_t        mem [DEPTH];
  dibit_t        rd_data_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == DEPTH_CNT);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = rd_data_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage and read register carry no reset so they map onto block RAM;
  // stale contents are harmless because the pointers/count are reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
    if (do_pop)  rd_data_q     <= mem[rd_ptr_q];
  end

endmodule

// File: rtl/iq_split.sv
// -----------------------------------------------------------------------------
// iq_split
// Pairs a handshaked serial bit stream into (I,Q) dibits (first bit I, second
// Q), buffers them, and emits one symbol every SYM_CYCLES clocks with a
// one-cycle sync_flag_o strobe; underflow_o pulses when a tick finds no data.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : iq_split_if.slave (serial handshake in, symbol outputs out)
// Parameters: SYM_CYCLES (>=2) cycles per symbol, FIFO_DEPTH (power of 2, >=2).
// Optional: define IQ_DIFF_ENC_EN to differentially encode each symbol
// (Gray -> phase increment, mod-4 accumulate, phase -> Gray).
// -----------------------------------------------------------------------------
module iq_split
  import qpsk_pkg::*;
#(
  parameter int SYM_CYCLES = 11,
  parameter int FIFO_DEPTH = 4
) (
  input logic     clk,
  input logic     rst_n,
  iq_split_if.slave bus
);

  localparam int TW = $clog2(SYM_CYCLES);
  localparam logic [TW-1:0] TICK_VAL = TW'(SYM_CYCLES - 1);

  // ---------------- assembler ----------------
  asm_state_e asm_q, asm_d;
  logic       i_q, i_d;
  logic       ser_ready, accept, push;
  dibit_t     push_data;

  // ---------------- fifo ----------------
  logic       pop, fifo_full, fifo_empty;
  dibit_t     fifo_rd_data;

  // ---------------- scheduler ----------------
  sch_state_e    sch_q, sch_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          pop_pend_q, pop_pend_d;     // FIFO read data lands next cycle
  logic          uflow_pend_q, uflow_pend_d; // keeps underflow aligned with flag slot
  dibit_t        sym_q, sym_d, sym_next;
  logic          flag_q, flag_d;
  logic          uflow_q, uflow_d;

  // Ready only looks at the registered full flag: a same-cycle pop never
  // frees room for the Q bit.
  assign ser_ready = (asm_q == WAIT_I) || !fifo_full;
  assign accept    = bus.ser_valid_i && ser_ready;
  assign push      = accept && (asm_q == WAIT_Q);
  assign push_data = {i_q, bus.ser_i};

  always_comb begin
    asm_d = asm_q;
    i_d   = i_q;
    if (accept) begin
      if (asm_q == WAIT_I) begin
        i_d   = bus.ser_i;
        asm_d = WAIT_Q;
      end else begin
        asm_d = WAIT_I;
      end
    end
  end

  iq_sym_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .rd_data   (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    sch_d        = sch_q;
    timer_d      = timer_q;
    pop          = 1'b0;
    pop_pend_d   = 1'b0;
    uflow_pend_d = 1'b0;
    case (sch_q)
      IDLE: begin
        timer_d = '0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          pop_pend_d = 1'b1;
          sch_d      = RUN;
        end
      end
      RUN: begin
        if (timer_q == TICK_VAL) begin
          timer_d = '0;
          if (!fifo_empty) begin
            pop        = 1'b1;
            pop_pend_d = 1'b1;
          end else begin
            uflow_pend_d = 1'b1;
            sch_d        = IDLE;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: sch_d = IDLE;
    endcase
  end

`ifdef IQ_DIFF_ENC_EN
  logic [1:0] phase_q, phase_d, phase_sum;

  assign phase_sum = phase_q + gray2phase(fifo_rd_data);
  assign sym_next  = phase2gray(phase_sum);

  always_comb begin
    phase_d = phase_q;
    if (pop_pend_q) phase_d = phase_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase_q <= '0;
    else        phase_q <= phase_d;
  end
`else
  assign sym_next = fifo_rd_data;
`endif

  always_comb begin
    sym_d   = sym_q;
    flag_d  = pop_pend_q;
    uflow_d = uflow_pend_q;
    if (pop_pend_q) sym_d = sym_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q        <= WAIT_I;
      i_q          <= 1'b0;
      sch_q        <= IDLE;
      timer_q      <= '0;
      pop_pend_q   <= 1'b0;
      uflow_pend_q <= 1'b0;
      sym_q        <= '0;
      flag_q       <= 1'b0;
      uflow_q      <= 1'b0;
    end else begin
      asm_q        <= asm_d;
      i_q          <= i_d;
      sch_q        <= sch_d;
      timer_q      <= timer_d;
      pop_pend_q   <= pop_pend_d;
      uflow_pend_q <= uflow_pend_d;
      sym_q        <= sym_d;
      flag_q       <= flag_d;
      uflow_q      <= uflow_d;
    end
  end

  assign bus.ser_ready_o = ser_ready;
  assign bus.sync_I      = sym_q[1];
  assign bus.sync_Q      = sym_q[0];
  assign bus.sync_flag_o = flag_q;
  assign bus.underflow_o = uflow_q;

endmodule
